// File: rtl/image_quan.sv
// Requantizes per-lane int32 accumulators to uint8: add bias, multiply by scale, round-shift, add zero point, clamp.
// Latency: 4 cycles at 1 beat/cycle. Backpressure: a stalled output freezes every stage and drops acc_ready.
`ifndef PICTURE_NUM
`define PICTURE_NUM 2
`endif
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

module image_quan #(
  parameter int WIDTH_DATA_ADD          = 32,
  parameter int COMPUTE_CHANNEL_OUT_NUM = 8
) (
  input  logic                                                            clk,
  input  logic                                                            rst_n,
  input  logic [`PICTURE_NUM*COMPUTE_CHANNEL_OUT_NUM*WIDTH_DATA_ADD-1:0]  acc_data_in,
  input  logic                                                            acc_valid,
  output logic                                                            acc_ready,
  input  logic [COMPUTE_CHANNEL_OUT_NUM*WIDTH_DATA_ADD-1:0]               bias_in,
  input  logic [COMPUTE_CHANNEL_OUT_NUM*WIDTH_DATA_ADD-1:0]               scale_in,
  input  logic [5:0]                                                      shift_in,
  input  logic [7:0]                                                      zero_point_in,
  input  logic [15:0]                                                     frame_len,
  output logic [`PICTURE_NUM*COMPUTE_CHANNEL_OUT_NUM*`WIDTH_DATA-1:0]     quan_data_out,
  output logic                                                            quan_valid,
  input  logic                                                            quan_ready,
  output logic                                                            frame_last
);
  localparam int PN = `PICTURE_NUM;
  localparam int N  = PN * COMPUTE_CHANNEL_OUT_NUM;
  localparam int WD = `WIDTH_DATA;
  localparam int WA = WIDTH_DATA_ADD;
  localparam int WS = WA + 1;
  localparam int WP = 2 * WS;
  localparam int WR = WP + 1;

  logic                 ce;
  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic                 quan_valid_q, quan_valid_d;
  logic [15:0]          beat_cnt_q, beat_cnt_d;
  logic [WR-1:0]        rnd;
  logic signed [WS-1:0] sum_q  [N];
  logic signed [WS-1:0] sum_d  [N];
  logic signed [WP-1:0] prod_q [N];
  logic signed [WP-1:0] prod_d [N];
  logic signed [WR-1:0] r_q    [N];
  logic signed [WR-1:0] r_d    [N];
  logic [N*WD-1:0]      quan_data_q, quan_data_d;

  always_comb begin
    ce           = quan_ready | ~quan_valid_q;
    v1_d         = v1_q;
    v2_d         = v2_q;
    v3_d         = v3_q;
    quan_valid_d = quan_valid_q;
    quan_data_d  = quan_data_q;
    rnd          = '0;
    if (shift_in != 6'd0) begin
      rnd = {{(WR-1){1'b0}}, 1'b1} << (shift_in - 6'd1);
    end
    for (int k = 0; k < N; k++) begin
      sum_d[k]  = sum_q[k];
      prod_d[k] = prod_q[k];
      r_d[k]    = r_q[k];
    end
    if (ce) begin
      v1_d         = acc_valid;
      v2_d         = v1_q;
      v3_d         = v2_q;
      quan_valid_d = v3_q;
      for (int k = 0; k < N; k++) begin
        // Lane k belongs to output channel k / PN.
        sum_d[k]  = $signed({acc_data_in[k*WA+WA-1], acc_data_in[k*WA +: WA]})
                  + $signed({bias_in[(k/PN)*WA+WA-1], bias_in[(k/PN)*WA +: WA]});
        prod_d[k] = sum_q[k] * $signed({1'b0, scale_in[(k/PN)*WA +: WA]});
        // Adding half an LSB before the arithmetic shift gives floor(x + 0.5); rnd is zero for shift 0.
        r_d[k]    = (($signed({prod_q[k][WP-1], prod_q[k]}) + $signed(rnd)) >>> shift_in)
                  + $signed({{(WR-8){1'b0}}, zero_point_in});
        if (r_q[k][WR-1]) begin
          quan_data_d[k*WD +: WD] = '0;
        end else if (|r_q[k][WR-2:WD]) begin
          quan_data_d[k*WD +: WD] = '1;
        end else begin
          quan_data_d[k*WD +: WD] = r_q[k][WD-1:0];
        end
      end
    end
  end

  always_comb begin
    frame_last = quan_valid_q && (beat_cnt_q == frame_len - 16'd1);
    beat_cnt_d = beat_cnt_q;
    if (quan_valid_q && quan_ready) begin
      beat_cnt_d = frame_last ? 16'd0 : beat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      v3_q         <= 1'b0;
      quan_valid_q <= 1'b0;
      beat_cnt_q   <= '0;
      quan_data_q  <= '0;
      for (int k = 0; k < N; k++) begin
        sum_q[k]  <= '0;
        prod_q[k] <= '0;
        r_q[k]    <= '0;
      end
    end else begin
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      v3_q         <= v3_d;
      quan_valid_q <= quan_valid_d;
      beat_cnt_q   <= beat_cnt_d;
      quan_data_q  <= quan_data_d;
      for (int k = 0; k < N; k++) begin
        sum_q[k]  <= sum_d[k];
        prod_q[k] <= prod_d[k];
        r_q[k]    <= r_d[k];
      end
    end
  end

  assign acc_ready     = ce;
  assign quan_valid    = quan_valid_q;
  assign quan_data_out = quan_data_q;

endmodule
